pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - five-stage pipeline stall/flush/halt controller (optional macro PIPELINE_CTRL_NOFWD_EN)
//
// Decides each cycle whether the PC and each pipeline latch advances, holds
// or takes a bubble. The priority order in RUN is:
//    data wait > taken branch > hazard > halt > fetch miss > advance.
// A HALT in decode lets the older instructions finish over three advancing
// DRAIN cycles. The controller then parks in HALTED until reset.
// Defining PIPELINE_CTRL_NOFWD_EN builds the variant without forwarding.
// In that build, any pending register write in EX or MEM that matches a
// decode source also stalls decode.

module pipeline_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic [4:0]       de_rs,
   input  logic [4:0]       de_rt,
   input  logic             de_usesRt,
   input  logic             de_halt,
   input  logic [4:0]       ex_regDst,
   input  logic             ex_regWr,
   input  logic             ex_dREN,
   input  logic [4:0]       mem_regDst,
   input  logic             mem_regWr,
   input  logic             mem_dREN,
   input  logic             mem_dWEN,
   input  logic             branch_taken,
   output logic             pc_en,
   output logic             ifde_en,
   output logic             ifde_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   // Number of advancing cycles needed to push EX, MEM and WB contents out
   localparam logic [1:0] DRAIN_LEN = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [1:0]       state_eff;
   logic [1:0]       drain_cnt_q, drain_cnt_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic dwait;
   logic load_use;
   logic hazard;
   logic ex_src_match;

   // While reset is asserted the outputs follow the RUN decode of the inputs
   always_comb begin
      state_eff = RST ? ST_RUN : state_q;
   end

   // Event detection: a memory access is waiting, or the decode sources depend on an older result
   always_comb begin
      dwait        = (mem_dREN | mem_dWEN) & ~dhit;
      ex_src_match = (ex_regDst == de_rs) | (de_usesRt & (ex_regDst == de_rt));
      // Register $0 is hardwired to zero, so it can never carry a dependency
      load_use     = ex_dREN & (ex_regDst != 5'd0) & ex_src_match;
   end

`ifdef PIPELINE_CTRL_NOFWD_EN
   logic ex_wr_hazard;
   logic mem_wr_hazard;

   // Without forwarding, any in-flight write to a decode source must retire first
   always_comb begin
      ex_wr_hazard  = ex_regWr & (ex_regDst != 5'd0) & ex_src_match;
      mem_wr_hazard = mem_regWr & (mem_regDst != 5'd0) &
                      ((mem_regDst == de_rs) | (de_usesRt & (mem_regDst == de_rt)));
      hazard        = load_use | ex_wr_hazard | mem_wr_hazard;
   end
`else
   logic unused_fwd_inputs;

   // Forwarding resolves ALU dependencies downstream, so only a load-use stalls
   always_comb begin
      hazard            = load_use;
      unused_fwd_inputs = ^{ex_regWr, mem_regWr, mem_regDst};
   end
`endif

   // Main decode: latch enables, bubble inserts and next state
   always_comb begin
      pc_en       = 1'b0;
      ifde_en     = 1'b0;
      ifde_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_flush  = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      halted      = 1'b0;
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;

      case (state_eff)
         ST_RUN: begin
            if (dwait) begin
               // Whole pipeline freezes until the data access completes
            end else if (branch_taken) begin
               // Redirect: squash the two younger instructions. A HALT in decode is wrong-path.
               pc_en      = 1'b1;
               ifde_en    = 1'b1;
               ifde_flush = 1'b1;
               idex_en    = 1'b1;
               idex_flush = 1'b1;
               exmem_en   = 1'b1;
               memwb_en   = 1'b1;
            end else if (hazard) begin
               // Hold fetch and decode, and send a bubble into EX
               idex_en    = 1'b1;
               idex_flush = 1'b1;
               exmem_en   = 1'b1;
               memwb_en   = 1'b1;
            end else if (de_halt) begin
               // Stop fetching and let everything older than the HALT drain
               ifde_en     = 1'b1;
               ifde_flush  = 1'b1;
               idex_en     = 1'b1;
               exmem_en    = 1'b1;
               memwb_en    = 1'b1;
               state_d     = ST_DRAIN;
               drain_cnt_d = DRAIN_LEN;
            end else if (!ihit) begin
               // Fetch miss: hold the PC and feed a bubble into decode
               ifde_en    = 1'b1;
               ifde_flush = 1'b1;
               idex_en    = 1'b1;
               exmem_en   = 1'b1;
               memwb_en   = 1'b1;
            end else begin
               pc_en    = 1'b1;
               ifde_en  = 1'b1;
               idex_en  = 1'b1;
               exmem_en = 1'b1;
               memwb_en = 1'b1;
            end
         end

         ST_DRAIN: begin
            if (!dwait) begin
               ifde_en    = 1'b1;
               ifde_flush = 1'b1;
               idex_en    = 1'b1;
               exmem_en   = 1'b1;
               memwb_en   = 1'b1;
               // The last advancing cycle takes the counter to zero and parks the controller
               if (drain_cnt_q <= 2'd1) begin
                  drain_cnt_d = 2'd0;
                  state_d     = ST_HALTED;
               end else begin
                  drain_cnt_d = drain_cnt_q - 2'd1;
               end
            end
         end

         ST_HALTED: begin
            halted = 1'b1;
         end

         default: begin
            // Unreachable encoding: fall back to RUN
            state_d     = ST_RUN;
            drain_cnt_d = 2'd0;
         end
      endcase
   end

   // Count RUN cycles in which the PC is frozen, saturating at all ones
   always_comb begin
      stall_d = stall_q;
      if ((state_eff == ST_RUN) && !pc_en && !(&stall_q)) begin
         stall_d = stall_q + CNT_W'(1);
      end
      stall_cycles = stall_q;
   end

   // State, drain counter and stall counter registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_RUN;
         drain_cnt_q <= 2'd0;
         stall_q     <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         stall_q     <= stall_d;
      end
   end

endmodule
